// File: rtl/dmem_arb_pkg.sv
// Shared types and default constants for the data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } arb_state_e;

    localparam int ADDR_W_DEF   = 5;
    localparam int DATA_W_DEF   = 32;
    localparam int MAX_WAIT_DEF = 4;
    localparam int WAIT_W       = 4;
    localparam int STAT_W       = 16;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == '1) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/dmem_arb_stats.sv
// Saturating counters of host grants and CPU stall cycles.
module dmem_arb_stats
    import dmem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              grant_i,
    input  logic              stall_i,
    output logic [STAT_W-1:0] host_grants_o,
    output logic [STAT_W-1:0] cpu_stalls_o
);

    logic [STAT_W-1:0] grants_q;
    logic [STAT_W-1:0] stalls_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grants_q <= '0;
            stalls_q <= '0;
        end else begin
            if (grant_i) grants_q <= sat_inc(grants_q);
            if (stall_i) stalls_q <= sat_inc(stalls_q);
        end
    end

    assign host_grants_o = grants_q;
    assign cpu_stalls_o  = stalls_q;

endmodule

// File: rtl/dmem_arbiter.sv
// CPU-priority arbiter for the data memory with a bounded host wait.
// Define DMEM_ARB_STATS_EN to add the grant/stall statistics outputs.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
   ,output logic [STAT_W-1:0] stat_host_grants,
    output logic [STAT_W-1:0] stat_cpu_stalls
`else
`endif
);

    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    arb_state_e        state_q;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic [WAIT_W-1:0] wait_cnt_d;
    logic              host_ack_q;
    logic [DATA_W-1:0] host_rdata_q;
    logic              wait_full;
    logic              grant;

    assign wait_full = (wait_cnt_q == WAIT_LIMIT);
    assign grant     = !reset && (state_q == IDLE) && host_req && (!cpu_req || wait_full);

    // The CPU owns memory unless the host is granted; nothing reaches memory during reset.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        cpu_stall = 1'b0;
        if (grant) begin
            mem_en    = 1'b1;
            mem_we    = host_we;
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
            cpu_stall = cpu_req;
        end else if (!reset) begin
            mem_en = cpu_req;
            mem_we = cpu_req && cpu_we;
        end
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_q == IDLE) begin
            if (grant || !host_req) begin
                wait_cnt_d = '0;
            end else if (cpu_req && !wait_full) begin
                wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            wait_cnt_q   <= '0;
            host_ack_q   <= 1'b0;
            host_rdata_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            host_ack_q <= grant;
            case (state_q)
                IDLE: begin
                    if (grant) begin
                        state_q      <= ACK;
                        host_rdata_q <= mem_rdata;
                    end
                end
                ACK:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cpu_rdata  = mem_rdata;
    assign host_ack   = host_ack_q;
    assign host_rdata = host_rdata_q;

`ifdef DMEM_ARB_STATS_EN
    dmem_arb_stats u_stats (
        .clk           (clk),
        .reset         (reset),
        .grant_i       (grant),
        .stall_i       (cpu_stall),
        .host_grants_o (stat_host_grants),
        .cpu_stalls_o  (stat_cpu_stalls)
    );
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-cycle core's data memory between the CPU load/store path and a host port used by debug and test loaders. The CPU has priority. A bounded wait counter guarantees the host a slot, stalling the CPU for one cycle when the limit is reached. It sits between the core's memory stage and the data memory, which has combinational read and synchronous write.

## Interface
- ADDR_W, 5, word-address width (32 words)
- DATA_W, 32, data width
- MAX_WAIT, 4, number of consecutive blocked host cycles before the host is forced in (1..15)

Ports:
- clk  in  1  clock; all state is updated on the rising edge
- reset  in  1  asynchronous, active-high
- cpu_req  in  1  CPU memory access this cycle
- cpu_we  in  1  CPU write enable
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_rdata  out  DATA_W  CPU read data, combinational from mem_rdata
- cpu_stall  out  1  CPU must hold its PC and suppress writeback this cycle
- host_req  in  1  host request, level, held until host_ack
- host_we  in  1  host write enable, stable while host_req
- host_addr  in  ADDR_W  host word address, stable while host_req
- host_wdata  in  DATA_W  host write data, stable while host_req
- host_ack  out  1  one-cycle completion pulse
- host_rdata  out  DATA_W  registered read data, valid with host_ack
- mem_en, mem_we  out  1  memory access and write strobes
- mem_addr  out  ADDR_W  memory word address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  combinational memory read data

## Operation
- States:
  - IDLE: host is eligible.
  - ACK: the cycle after a host grant. Host is ineligible, so a held host_req is not serviced twice.
- Host grant condition, evaluated in IDLE: host_req && (!cpu_req || wait_cnt == MAX_WAIT).
- In the grant cycle:
  - mem_* are driven from the host port.
  - cpu_stall = cpu_req.
  - At the clock edge: host_rdata <= mem_rdata, host_ack <= 1, state goes to ACK, wait_cnt <= 0.
- Otherwise the CPU owns memory:
  - mem_en = cpu_req, mem_we = cpu_req && cpu_we.
  - mem_addr and mem_wdata come from the CPU port.
  - cpu_stall = 0.
- Wait counter in IDLE:
  - Increments (saturating at MAX_WAIT) when host_req is blocked by cpu_req.
  - Clears whenever host_req = 0.
- ACK always returns to IDLE after one cycle. host_ack drops in the cycle after it was asserted.
- The host may lower host_req in the ACK cycle, or re-present a new request. A new request is eligible no earlier than the cycle after ACK.
- The grant decision and all mem_* values are combinational from registered state and the current inputs. There are no combinational paths from mem_rdata to any control output.

## Timing
- Host latency with no CPU traffic: req seen in cycle N, grant in N, host_ack in N+1. The minimum request-to-request period is 2 cycles.
- Worst-case host latency under continuous CPU traffic: MAX_WAIT blocked cycles, then the grant. host_ack is asserted MAX_WAIT+1 cycles after host_req first rises.
- The CPU never stalls for more than 1 cycle per host transaction, and never in 2 consecutive cycles.
- Reset values: state IDLE, wait_cnt 0, host_ack 0, host_rdata 0, and statistics counters 0 when compiled in.
- While reset is asserted:
  - mem_en = 0, mem_we = 0, cpu_stall = 0.
  - cpu_rdata still follows mem_rdata.
- Reset asserted in the ACK cycle clears host_ack immediately. The host must re-issue its request. A write already committed at the grant edge stands.
- Simultaneous CPU and host writes to the same address are impossible, because only one port drives memory in any cycle.

## Configuration
- DMEM_ARB_STATS_EN defined:
  - Adds outputs stat_host_grants and stat_cpu_stalls, each 16 bits.
  - They count host grants and cycles with cpu_stall = 1, and saturate at 16'hFFFF.
  - Both clear on reset.
- Undefined: the statistics ports and logic are absent and all other behaviour is identical.

## Structure
- Package dmem_arb_pkg holds:
  - the state enum (IDLE, ACK);
  - default width constants ADDR_W_DEF = 5, DATA_W_DEF = 32;
  - MAX_WAIT_DEF = 4 and the counter width WAIT_W = 4.
- Sub-module dmem_arb_stats implements the two saturating counters. It is instantiated only under DMEM_ARB_STATS_EN.

## Test plan
- Idle CPU; host read of addr 2 holding 32'h5 -> host_ack in the next cycle with host_rdata = 32'h5; cpu_stall never asserts.
- Idle CPU; host write of 32'hA to addr 9, then a CPU read of addr 9 -> cpu_rdata = 32'hA.
- cpu_req held high continuously; host_req rises in cycle 0 -> cpu_stall = 1 in exactly cycle 4, host_ack in cycle 5, CPU writes in cycles 0..3 and 5+ land in memory, and the stalled cycle-4 write does not.
- host_req held high for 6 cycles with the CPU idle -> exactly 3 host_ack pulses, in cycles 1, 3 and 5.
- Reset asserted in the ACK cycle after a host write of 32'h7 to addr 11 -> host_ack is 0 at once, addr 11 holds 32'h7, and the FSM is in IDLE after reset is released.
- With DMEM_ARB_STATS_EN, run the contended scenario twice -> stat_host_grants = 2, stat_cpu_stalls = 2.
